// File: rtl/crossbar_pkg.sv
// Shared types and helpers for the crossbar shift scheduler.
// Optional statistics counters are enabled by defining XBAR_SCHED_STATS_EN.
package crossbar_pkg;

    localparam int XBAR_N = 8;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        ISSUE
    } sched_state_e;

    typedef logic [$clog2(XBAR_N)-1:0] sel_t;

    // Circular shift that routes input 'sel' onto output 'idx': (sel - idx) mod n.
    function automatic int calc_shift(input int sel, input int idx, input int n);
        return (sel + n - idx) % n;
    endfunction

endpackage

// File: rtl/crossbar_shift_calc.sv
// Combinational per-output shift vector and collision detection for one mapping.
// Part of crossbar_shift_scheduler (stats option: XBAR_SCHED_STATS_EN).
module crossbar_shift_calc
    import crossbar_pkg::*;
#(
    parameter int N  = XBAR_N,
    parameter int SW = $clog2(N)
) (
    input  logic [N*SW-1:0] sel,
    input  logic [N-1:0]    en,
    output logic [N*SW-1:0] shift,
    output logic            collision
);

    always_comb begin
        shift     = '0;
        collision = 1'b0;
        for (int i = 0; i < N; i++) begin
            shift[i*SW +: SW] = SW'(calc_shift(int'(sel[i*SW +: SW]), i, N));
            for (int j = i + 1; j < N; j++) begin
                if (en[i] && en[j] && (sel[i*SW +: SW] == sel[j*SW +: SW])) begin
                    collision = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/crossbar_shift_scheduler.sv
// Decomposes an output->input crossbar mapping into barrel-shifter passes, one per distinct shift.
// Define XBAR_SCHED_STATS_EN to build the saturating request/collision/beat counters.
module crossbar_shift_scheduler
    import crossbar_pkg::*;
#(
    parameter int N  = XBAR_N,
    parameter int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [N*SW-1:0] req_sel,
    input  logic [N-1:0]    req_en,
    output logic            sched_valid,
    input  logic            sched_ready,
    output logic [SW-1:0]   sched_shift,
    output logic [N-1:0]    sched_out_en,
    output logic            sched_last,
    output logic            sched_multi,
    output logic            collision_error,
    output logic            busy,
    output logic [15:0]     stat_req,
    output logic [15:0]     stat_coll,
    output logic [15:0]     stat_beat
);

    sched_state_e    state_q, state_d;
    logic [N*SW-1:0] sel_q, sel_d;
    logic [N-1:0]    en_q, en_d;
    logic [N*SW-1:0] shift_q, shift_d;
    logic [N-1:0]    pending_q, pending_d;
    logic [SW-1:0]   beat_shift_q, beat_shift_d;
    logic [N-1:0]    out_en_q, out_en_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic            multi_q, multi_d;
    logic            coll_q, coll_d;

    logic [N*SW-1:0] calc_shift_vec;
    logic            calc_coll;
    logic            multi_calc;
    logic            have_first;
    logic [SW-1:0]   first_shift;
    logic [N-1:0]    remain;
    logic [SW-1:0]   beat_min;
    logic [N-1:0]    beat_mask;

    crossbar_shift_calc #(.N(N), .SW(SW)) u_calc (
        .sel       (sel_q),
        .en        (en_q),
        .shift     (calc_shift_vec),
        .collision (calc_coll)
    );

    function automatic logic [SW-1:0] min_shift_of(input logic [N*SW-1:0] sv, input logic [N-1:0] m);
        logic [SW-1:0] best;
        best = '1;
        for (int i = 0; i < N; i++) begin
            if (m[i] && (sv[i*SW +: SW] < best)) best = sv[i*SW +: SW];
        end
        return best;
    endfunction

    function automatic logic [N-1:0] mask_of(input logic [N*SW-1:0] sv, input logic [N-1:0] m,
                                             input logic [SW-1:0] s);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i] = m[i] && (sv[i*SW +: SW] == s);
        return r;
    endfunction

    // More than one pass is needed exactly when two enabled outputs disagree on shift.
    always_comb begin
        multi_calc  = 1'b0;
        have_first  = 1'b0;
        first_shift = '0;
        for (int i = 0; i < N; i++) begin
            if (en_q[i]) begin
                if (!have_first) begin
                    have_first  = 1'b1;
                    first_shift = calc_shift_vec[i*SW +: SW];
                end else if (calc_shift_vec[i*SW +: SW] != first_shift) begin
                    multi_calc = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        en_d         = en_q;
        shift_d      = shift_q;
        pending_d    = pending_q;
        beat_shift_d = beat_shift_q;
        out_en_d     = out_en_q;
        valid_d      = valid_q;
        last_d       = last_q;
        multi_d      = multi_q;
        coll_d       = 1'b0;
        remain       = '0;
        beat_min     = '0;
        beat_mask    = '0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    sel_d   = req_sel;
                    en_d    = req_en;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                shift_d   = calc_shift_vec;
                pending_d = en_q;
                if (calc_coll) begin
                    coll_d  = 1'b1;
                    state_d = IDLE;
                end else if (en_q == '0) begin
                    state_d = IDLE;
                end else begin
                    multi_d = multi_calc;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // A fresh beat is loaded on entry and after every handshake; otherwise the beat holds.
                remain    = (valid_q && sched_ready) ? (pending_q & ~out_en_q) : pending_q;
                pending_d = remain;
                if (!valid_q || sched_ready) begin
                    if (remain == '0) begin
                        state_d      = IDLE;
                        valid_d      = 1'b0;
                        last_d       = 1'b0;
                        multi_d      = 1'b0;
                        out_en_d     = '0;
                        beat_shift_d = '0;
                    end else begin
                        beat_min     = min_shift_of(shift_q, remain);
                        beat_mask    = mask_of(shift_q, remain, beat_min);
                        beat_shift_d = beat_min;
                        out_en_d     = beat_mask;
                        last_d       = ((remain & ~beat_mask) == '0);
                        valid_d      = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            en_q         <= '0;
            shift_q      <= '0;
            pending_q    <= '0;
            beat_shift_q <= '0;
            out_en_q     <= '0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            multi_q      <= 1'b0;
            coll_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            en_q         <= en_d;
            shift_q      <= shift_d;
            pending_q    <= pending_d;
            beat_shift_q <= beat_shift_d;
            out_en_q     <= out_en_d;
            valid_q      <= valid_d;
            last_q       <= last_d;
            multi_q      <= multi_d;
            coll_q       <= coll_d;
        end
    end

    assign req_ready       = (state_q == IDLE);
    assign busy            = (state_q != IDLE);
    assign sched_valid     = valid_q;
    assign sched_shift     = beat_shift_q;
    assign sched_out_en    = out_en_q;
    assign sched_last      = last_q;
    assign sched_multi     = multi_q;
    assign collision_error = coll_q;

`ifdef XBAR_SCHED_STATS_EN
    logic [15:0] stat_req_q, stat_req_d;
    logic [15:0] stat_coll_q, stat_coll_d;
    logic [15:0] stat_beat_q, stat_beat_d;

    always_comb begin
        stat_req_d  = stat_req_q;
        stat_coll_d = stat_coll_q;
        stat_beat_d = stat_beat_q;
        if ((state_q == IDLE) && req_valid && (stat_req_q != 16'hFFFF)) stat_req_d = stat_req_q + 16'd1;
        if ((state_q == CHECK) && calc_coll && (stat_coll_q != 16'hFFFF)) stat_coll_d = stat_coll_q + 16'd1;
        if ((state_q == ISSUE) && valid_q && sched_ready && (stat_beat_q != 16'hFFFF)) stat_beat_d = stat_beat_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_req_q  <= '0;
            stat_coll_q <= '0;
            stat_beat_q <= '0;
        end else begin
            stat_req_q  <= stat_req_d;
            stat_coll_q <= stat_coll_d;
            stat_beat_q <= stat_beat_d;
        end
    end

    assign stat_req  = stat_req_q;
    assign stat_coll = stat_coll_q;
    assign stat_beat = stat_beat_q;
`else
    assign stat_req  = '0;
    assign stat_coll = '0;
    assign stat_beat = '0;
`endif

endmodule
